// File: rtl/bist_pkg.sv
// Shared BIST definitions: signature-check FSM states and default widths/constants
// used by the MISR, its flush logic and the signature check stage.
package bist_pkg;

    localparam int              SIG_W_DEF      = 3;
    localparam logic [2:0]      GOLDEN_DEF     = 3'b000;
    localparam int              SETTLE_CYC_DEF = 2;
    localparam int              CNT_W_DEF      = 8;

    typedef enum logic [2:0] {
        IDLE,
        ARMED,
        SETTLE,
        COMPARE,
        REPORT
    } sigchk_state_t;

endpackage

// File: rtl/bist_sig_check_if.sv
// Control, signature and status bundle between the BIST sequencing side (master)
// and the signature check stage (slave).
interface bist_sig_check_if #(
    parameter int SIG_W = 3,
    parameter int CNT_W = 8
);
    logic             bist_start;
    logic             finish;
    logic [SIG_W-1:0] sig;
    logic             pass_fail;
    logic             done;
    logic [SIG_W-1:0] sig_cap;
    logic [CNT_W-1:0] fail_cnt;

    modport master (
        output bist_start, finish, sig,
        input  pass_fail, done, sig_cap, fail_cnt
    );

    modport slave (
        input  bist_start, finish, sig,
        output pass_fail, done, sig_cap, fail_cnt
    );
endinterface

// File: rtl/bist_sat_counter.sv
// Parameterised saturating up-counter with enable and synchronous active-low clear;
// holds at all-ones instead of wrapping.
module bist_sat_counter #(
    parameter int W = 8
) (
    input  logic         CLK,
    input  logic         i_clr_n,
    input  logic         i_en,
    output logic [W-1:0] o_cnt
);

    logic [W-1:0] r_cnt;

    // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge CLK) begin
        if (!i_clr_n) begin
            r_cnt <= '0;
        end else if (i_en && (r_cnt != '1)) begin
            r_cnt <= r_cnt + W'(1);
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/bist_sig_check.sv
// BIST signature check: waits for finish, lets the MISR flush, compares against GOLDEN.
// Optional macro SIGCHK_STICKY_EN: any failed compare forces pass_fail low until reset.
module bist_sig_check
    import bist_pkg::*;
#(
    parameter int               SIG_W      = SIG_W_DEF,
    parameter logic [SIG_W-1:0] GOLDEN     = SIG_W'(GOLDEN_DEF),
    parameter int               SETTLE_CYC = SETTLE_CYC_DEF,
    parameter int               CNT_W      = CNT_W_DEF
) (
    input logic                CLK,
    input logic                RST,
    bist_sig_check_if.slave    bus
);

    localparam int SCNT_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam logic [SCNT_W-1:0] SCNT_LOAD = (SETTLE_CYC > 0) ? SCNT_W'(SETTLE_CYC - 1) : '0;

    sigchk_state_t     r_state;
    sigchk_state_t     w_next_state;
    logic [SCNT_W-1:0] r_settle_cnt;
    logic              r_done;
    logic              r_pass_fail;
    logic [SIG_W-1:0]  r_sig_cap;
    logic [CNT_W-1:0]  w_fail_cnt;
    logic              w_cnt_load;
    logic              w_cnt_dec;
    logic              w_compare;
    logic              w_match;
    logic              w_sticky_fail;

    assign w_match = (bus.sig == GOLDEN);

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        w_next_state = r_state;
        w_cnt_load   = 1'b0;
        w_cnt_dec    = 1'b0;
        w_compare    = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (bus.bist_start) w_next_state = ARMED;
            end
            ARMED: begin
                // finish takes priority over a coincident bist_start
                if (bus.finish) begin
                    if (SETTLE_CYC == 0) begin
                        w_next_state = COMPARE;
                    end else begin
                        w_next_state = SETTLE;
                        w_cnt_load   = 1'b1;
                    end
                end
            end
            SETTLE: begin
                if (r_settle_cnt == '0) w_next_state = COMPARE;
                else                    w_cnt_dec    = 1'b1;
            end
            COMPARE: begin
                w_compare    = 1'b1;
                w_next_state = REPORT;
            end
            REPORT: begin
                if (bus.bist_start) w_next_state = ARMED;
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            r_state      <= IDLE;
            r_settle_cnt <= '0;
            r_done       <= 1'b0;
            r_pass_fail  <= 1'b0;
            r_sig_cap    <= '0;
        end else begin
            r_state <= w_next_state;
            r_done  <= (w_next_state == REPORT);
            if (w_cnt_load)     r_settle_cnt <= SCNT_LOAD;
            else if (w_cnt_dec) r_settle_cnt <= r_settle_cnt - SCNT_W'(1);
            if (w_compare) begin
                r_sig_cap   <= bus.sig;
                r_pass_fail <= w_match && !w_sticky_fail;
            end
        end
    end

`ifdef SIGCHK_STICKY_EN
    logic r_any_fail;

    always_ff @(posedge CLK) begin
        if (!RST)                      r_any_fail <= 1'b0;
        else if (w_compare && !w_match) r_any_fail <= 1'b1;
    end

    assign w_sticky_fail = r_any_fail;
`else
    assign w_sticky_fail = 1'b0;
`endif

    bist_sat_counter #(
        .W (CNT_W)
    ) u_fail_cnt (
        .CLK     (CLK),
        .i_clr_n (RST),
        .i_en    (w_compare && !w_match),
        .o_cnt   (w_fail_cnt)
    );

    assign bus.done      = r_done;
    assign bus.pass_fail = r_pass_fail;
    assign bus.sig_cap   = r_sig_cap;
    assign bus.fail_cnt  = w_fail_cnt;

endmodule

// File: doc/bist_sig_check.md
# bist_sig_check

Signature check and pass/fail stage of the BIST path, directly downstream of the MISR. It waits for the BIST controller's finish pulse, lets the MISR flush for a programmable number of cycles, captures the signature, and compares it with a golden value. It then reports a registered pass/fail with a done flag and keeps a saturating count of failed runs. Its outputs drive the top-level pass_fail and the BIST status outputs.

## Interface
- SIG_W, 3: MISR signature width.
- GOLDEN, 3'b000: expected fault-free signature; set per circuit at instantiation.
- SETTLE_CYC, 2: cycles to wait after finish before sampling the MISR; 0 is legal.
- CNT_W, 8: width of the failed-run counter.
- CLK  in  1  system clock; all logic is on the rising edge.
- RST  in  1  reset; synchronous and active-low, one clock, as decided.
- bist_start  in  1  BIST start request, the same signal that feeds the BIST controller.
- finish  in  1  one-cycle pulse from the BIST controller marking the end of the test pattern sequence.
- sig  in  SIG_W  MISR signature, {h2,h1,h0}.
- pass_fail  out  1  1 = last evaluated run passed; 0 = failed or no run evaluated yet.
- done  out  1  evaluation complete; pass_fail and sig_cap are valid while done is high.
- sig_cap  out  SIG_W  signature captured at compare time.
- fail_cnt  out  CNT_W  number of failed runs, saturating.

## Operation
- FSM states: IDLE, ARMED, SETTLE, COMPARE, REPORT. Encoding is a package enum.
- IDLE:
  - bist_start=1 goes to ARMED.
  - finish is ignored.
- ARMED:
  - finish=1 goes to SETTLE and loads the settle counter with SETTLE_CYC-1.
  - If SETTLE_CYC=0, finish goes directly to COMPARE.
  - bist_start is ignored.
- SETTLE:
  - The counter decrements each cycle; at 0 the FSM goes to COMPARE.
  - bist_start and finish are ignored.
- COMPARE, exactly one cycle:
  - sig_cap <= sig.
  - pass_fail <= (sig == GOLDEN).
  - On a mismatch, fail_cnt increments unless it is at all-ones; it saturates there.
  - Next state is REPORT.
- REPORT:
  - done=1 and the outputs hold.
  - bist_start=1 goes to ARMED and clears done in the same edge; pass_fail, sig_cap and fail_cnt hold until the next COMPARE.
- done is 0 in every state except REPORT.
- Simultaneous bist_start and finish in ARMED: finish wins and bist_start is dropped.
- Reset while in any state returns to IDLE on that edge and clears all outputs.

## Timing
- Reset values:
  - state = IDLE.
  - pass_fail = 0, done = 0, sig_cap = 0, fail_cnt = 0.
  - Settle counter = 0.
- bist_start sampled at edge t puts the FSM in ARMED from edge t.
- With finish sampled at edge t:
  - SETTLE occupies edges t..t+SETTLE_CYC-1.
  - COMPARE is entered at edge t+SETTLE_CYC.
  - sig is sampled and done rises at edge t+SETTLE_CYC+1.
  - For SETTLE_CYC=0, done rises at edge t+1.
- All outputs are registered, with no combinational path from inputs to outputs.
- sig must be stable from edge t+SETTLE_CYC to t+SETTLE_CYC+1. The MISR guarantees this because it is not clocked with new data after finish plus its flush.

## Configuration
- SIGCHK_STICKY_EN defined:
  - Once any COMPARE fails, pass_fail stays 0 through all later runs until reset.
  - sig_cap and fail_cnt still update normally.
- SIGCHK_STICKY_EN undefined: pass_fail reflects only the most recent COMPARE.

## Structure
- Shared package bist_pkg holds:
  - The state enum sigchk_state_t.
  - The default SIG_W and GOLDEN constants.
  - The default SETTLE_CYC, also used by the MISR flush logic.
- One sub-module, bist_sat_counter, implements the parameterised saturating up-counter with enable and synchronous active-low clear, used for fail_cnt.
- The settle counter stays inline in bist_sig_check.

## Test plan
- Reset, then bist_start, finish, sig=GOLDEN (3'b000), SETTLE_CYC=2 -> done rises exactly 3 edges after the finish edge; pass_fail=1, sig_cap=3'b000, fail_cnt=0.
- Run with sig=3'b101 -> pass_fail=0, sig_cap=3'b101, fail_cnt=1. Next run with a golden sig:
  - without SIGCHK_STICKY_EN -> pass_fail=1, fail_cnt=1;
  - with SIGCHK_STICKY_EN -> pass_fail=0.
- CNT_W=2, five failing runs -> fail_cnt sequence 1,2,3,3,3 (saturates, no wrap).
- bist_start and finish asserted in the same cycle while ARMED -> FSM enters SETTLE and done follows the normal latency. finish pulse while IDLE -> no state change, done stays 0.
- RST=0 for one cycle while in SETTLE -> next edge: state IDLE, all outputs 0. A later finish without bist_start -> ignored.
- SETTLE_CYC=0 -> done rises 1 edge after finish; sig is sampled at that same edge.
